// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential multiply/divide unit with architectural HI/LO registers.
// An iterative shift-add multiplier and a restoring divider share one pair of
// working registers. A busy/done handshake lets the CPU control FSM stall on a
// HI/LO hazard.
// Optional feature macro: MULDIV_FAST_MUL_EN. When it is defined, multiplies
// use a single-cycle 64-bit multiplier and finish in 2 cycles.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  func,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] OP_MULT  = 6'b000111;
    localparam logic [5:0] OP_MULTU = 6'b001011;
    localparam logic [5:0] OP_DIV   = 6'b010011;
    localparam logic [5:0] OP_DIVU  = 6'b100011;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [31:0] rem;       // partial remainder (divide) / upper product half (multiply)
    logic [31:0] quo;       // dividend->quotient (divide) / multiplier->lower product (multiply)
    logic [31:0] divisor;   // |b|, used as divisor or multiplicand
    logic        neg_res;
    logic        neg_rem;
    logic        is_div;
    logic        div_zero;

    logic        func_ok;
    logic        func_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] rem_sub;

    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Decode the request and form operand magnitudes for signed ops.
    always_comb begin
        func_ok  = (func == OP_MULT) || (func == OP_MULTU) ||
                   (func == OP_DIV)  || (func == OP_DIVU);
        func_div = (func == OP_DIV) || (func == OP_DIVU);
        a_neg    = ((func == OP_MULT) || (func == OP_DIV)) && a[31];
        b_neg    = ((func == OP_MULT) || (func == OP_DIV)) && b[31];
        a_mag    = a_neg ? (~a + 32'd1) : a;
        b_mag    = b_neg ? (~b + 32'd1) : b;
    end

    // One engine iteration. The shift-add step adds the multiplicand when the
    // multiplier LSB is set. The restoring step compares the 33-bit shifted
    // remainder against the divisor.
    always_comb begin
        mul_sum   = {1'b0, rem} + (quo[0] ? {1'b0, divisor} : 33'd0);
        div_shift = {rem, quo[31]};
        div_ge    = (div_shift >= {1'b0, divisor});
        rem_sub   = div_shift[31:0] - divisor;
    end

    // Sign correction of the finished result.
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_mag = {32'd0, quo} * {32'd0, divisor};
`else
        prod_mag = {rem, quo};
`endif
        prod  = neg_res ? (~prod_mag + 64'd1) : prod_mag;
        q_fix = neg_res ? (~quo + 32'd1) : quo;
        r_fix = neg_rem ? (~rem + 32'd1) : rem;
    end

    // Control FSM, engine datapath and architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= 6'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            divisor  <= 32'd0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div0     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && func_ok) begin
                        quo      <= a_mag;
                        divisor  <= b_mag;
                        rem      <= 32'd0;
                        count    <= 6'd0;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        is_div   <= func_div;
                        div_zero <= (b == 32'd0);
                        busy     <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        state    <= func_div ? CALC : FIX;
`else
                        state    <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (is_div) begin
                        if (div_ge) begin
                            rem <= rem_sub;
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= div_shift[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                    end else begin
                        rem <= mul_sum[32:1];
                        quo <= {mul_sum[0], quo[31:1]};
                    end
                    count <= count + 6'd1;
                    if (count == 6'd31) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        if (div_zero) begin
                            div0 <= 1'b1;
                        end else begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// It runs directed cases plus randomized operations against a plain
// arithmetic reference model of HI/LO. Honours MULDIV_FAST_MUL_EN for the
// expected multiply latency.
module tb_muldiv_unit;

    localparam logic [5:0] OP_MULT  = 6'b000111;
    localparam logic [5:0] OP_MULTU = 6'b001011;
    localparam logic [5:0] OP_DIV   = 6'b010011;
    localparam logic [5:0] OP_DIVU  = 6'b100011;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_LAT  = 34;
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_LAT  = 34;
    localparam int DIV_BUSY = 33;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          errors;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .func  (func),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: new {HI,LO} from plain arithmetic; divide by zero keeps prev.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] prev);
        longint          sx;
        longint          sy;
        longint          q;
        longint          r;
        longint unsigned p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            OP_MULT:  begin p = longint'(sx * sy); return p; end
            OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; return p; end
            OP_DIV: begin
                if (y == 32'd0) return prev;
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (y == 32'd0) return prev;
                return {x % y, x / y};
            end
            default: return prev;
        endcase
    endfunction

    function automatic int lat_of(input logic [5:0] f);
        return (f == OP_DIV || f == OP_DIVU) ? DIV_LAT : MUL_LAT;
    endfunction

    function automatic int busy_of(input logic [5:0] f);
        return (f == OP_DIV || f == OP_DIVU) ? DIV_BUSY : MUL_BUSY;
    endfunction

    // Drives one request and waits (bounded) for done. lat = 0 means timeout.
    task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] ohi, output logic [31:0] olo,
                         output logic odiv0, output int lat, output int nbusy);
        func  = f;
        a     = x;
        b     = y;
        start = 1'b1;
        lat   = 0;
        nbusy = 0;
        odiv0 = 1'b0;
        ohi   = 32'hx;
        olo   = 32'hx;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat   = i;
                ohi   = hi;
                olo   = lo;
                odiv0 = div0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; func = 6'd0; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        checks++; if ({busy, done, div0} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, div0}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        logic [31:0] ohi, olo; logic od; int lat, nb;
        do_op(OP_MULT, 32'hFFFFFFFE, 32'd3, ohi, olo, od, lat, nb);
        {exp_hi, exp_lo} = 64'hFFFFFFFF_FFFFFFFA;
        checks++; if (lat !== MUL_LAT) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected %0d", lat, MUL_LAT); end
        checks++; if (ohi !== exp_hi) begin errors++; $display("[TB] FAIL mult_hi: got %h expected %h", ohi, exp_hi); end
        checks++; if (olo !== exp_lo) begin errors++; $display("[TB] FAIL mult_lo: got %h expected %h", olo, exp_lo); end
    endtask

    task automatic test_multu();
        logic [31:0] ohi, olo; logic od; int lat, nb;
        do_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, ohi, olo, od, lat, nb);
        {exp_hi, exp_lo} = 64'h00000002_FFFFFFFA;
        checks++; if (nb !== MUL_BUSY) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d expected %0d", nb, MUL_BUSY); end
        checks++; if (ohi !== exp_hi) begin errors++; $display("[TB] FAIL multu_hi: got %h expected %h", ohi, exp_hi); end
        checks++; if (olo !== exp_lo) begin errors++; $display("[TB] FAIL multu_lo: got %h expected %h", olo, exp_lo); end
    endtask

    task automatic test_div();
        logic [31:0] ohi, olo; logic od; int lat, nb;
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, ohi, olo, od, lat, nb);
        {exp_hi, exp_lo} = 64'hFFFFFFFF_FFFFFFFD;
        checks++; if ({ohi, olo} !== {exp_hi, exp_lo}) begin errors++; $display("[TB] FAIL div_neg7_by2: got %h expected %h", {ohi, olo}, {exp_hi, exp_lo}); end
        checks++; if (od !== 1'b0) begin errors++; $display("[TB] FAIL div_no_div0: got %b expected 0", od); end
        checks++; if (lat !== DIV_LAT) begin errors++; $display("[TB] FAIL div_latency: got %0d expected %0d", lat, DIV_LAT); end
        do_op(OP_DIVU, 32'd100, 32'd7, ohi, olo, od, lat, nb);
        {exp_hi, exp_lo} = {32'd2, 32'd14};
        checks++; if ({ohi, olo} !== {exp_hi, exp_lo}) begin errors++; $display("[TB] FAIL divu_100_by7: got %h expected %h", {ohi, olo}, {exp_hi, exp_lo}); end
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, ohi, olo, od, lat, nb);
        {exp_hi, exp_lo} = {32'd0, 32'h80000000};
        checks++; if ({ohi, olo} !== {exp_hi, exp_lo}) begin errors++; $display("[TB] FAIL div_overflow: got %h expected %h", {ohi, olo}, {exp_hi, exp_lo}); end
    endtask

    task automatic test_div0();
        logic [31:0] ohi, olo; logic od; int lat, nb;
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        @(posedge clk); #1;
        lo_we = 1'b0;
        exp_hi = 32'h1234; exp_lo = 32'h5678;
        checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("[TB] FAIL mthi_mtlo: got %h expected %h", {hi, lo}, {exp_hi, exp_lo}); end
        do_op(OP_DIVU, 32'd99, 32'd0, ohi, olo, od, lat, nb);
        checks++; if (od !== 1'b1) begin errors++; $display("[TB] FAIL div0_flag: got %b expected 1", od); end
        checks++; if (lat !== DIV_LAT) begin errors++; $display("[TB] FAIL div0_latency: got %0d expected %0d", lat, DIV_LAT); end
        checks++; if ({ohi, olo} !== {exp_hi, exp_lo}) begin errors++; $display("[TB] FAIL div0_keep: got %h expected %h", {ohi, olo}, {exp_hi, exp_lo}); end
        @(posedge clk); #1;
        checks++; if ({done, div0} !== 2'b00) begin errors++; $display("[TB] FAIL div0_pulse_width: got %b expected 00", {done, div0}); end
    endtask

    task automatic test_random();
        logic [31:0] ohi, olo, x, y; logic od; int lat, nb;
        logic [5:0] f; logic exp_d0;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: f = OP_MULT;
                1: f = OP_MULTU;
                2: f = OP_DIV;
                default: f = OP_DIVU;
            endcase
            x = $urandom();
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 31);
            exp_d0 = (f == OP_DIV || f == OP_DIVU) && (y == 32'd0);
            {exp_hi, exp_lo} = model(f, x, y, {exp_hi, exp_lo});
            do_op(f, x, y, ohi, olo, od, lat, nb);
            checks++;
            if ({ohi, olo} !== {exp_hi, exp_lo} || od !== exp_d0 || lat !== lat_of(f) || nb !== busy_of(f)) begin
                errors++;
                $display("[TB] FAIL random_op f=%b a=%h b=%h: got hilo=%h div0=%b lat=%0d busy=%0d expected hilo=%h div0=%b lat=%0d busy=%0d",
                         f, x, y, {ohi, olo}, od, lat, nb, {exp_hi, exp_lo}, exp_d0, lat_of(f), busy_of(f));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ohi, olo; logic od; int lat, nb;
        do_op(OP_MULTU, 32'd7, 32'd9, ohi, olo, od, lat, nb);
        {exp_hi, exp_lo} = {32'd0, 32'd63};
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_state: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        do_op(OP_DIVU, 32'd1000, 32'd33, ohi, olo, od, lat, nb);
        {exp_hi, exp_lo} = {32'd10, 32'd30};
        checks++; if ({ohi, olo} !== {exp_hi, exp_lo} || lat !== DIV_LAT) begin errors++; $display("[TB] FAIL b2b_second: got %h lat=%0d expected %h lat=%0d", {ohi, olo}, lat, {exp_hi, exp_lo}, DIV_LAT); end
    endtask

    task automatic test_ignore();
        int ndone, first;
        logic hi_leak;
        func = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        ndone = 0; first = 0; hi_leak = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (i == 4) begin
                start = 1'b1; func = OP_MULTU; a = 32'd1000; b = 32'd3;
                hi_we = 1'b1; wdata = 32'hDEADBEEF;
            end
            if (i == 5) begin start = 1'b0; hi_we = 1'b0; end
            if (i == 6 && hi !== exp_hi) hi_leak = 1'b1;
            if (done) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        {exp_hi, exp_lo} = {32'd2, 32'd14};
        checks++; if (hi_leak !== 1'b0) begin errors++; $display("[TB] FAIL ignore_mthi_busy: got leak=%b expected 0", hi_leak); end
        checks++; if (ndone !== 1 || first !== DIV_LAT) begin errors++; $display("[TB] FAIL ignore_restart: got dones=%0d at %0d expected 1 at %0d", ndone, first, DIV_LAT); end
        checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("[TB] FAIL ignore_result: got %h expected %h", {hi, lo}, {exp_hi, exp_lo}); end
    endtask

    task automatic test_invalid_func();
        logic seen;
        seen = 1'b0;
        func = 6'b000000; a = 32'd5; b = 32'd5; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy || done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL invalid_func: got activity=%b expected 0", seen); end
        checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("[TB] FAIL invalid_func_hilo: got %h expected %h", {hi, lo}, {exp_hi, exp_lo}); end
    endtask

    task automatic test_mt_same_cycle();
        int lat;
        func = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEF00D;
        lat = 0;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        checks++; if ({hi, lo, busy} !== {32'hCAFEF00D, 32'hCAFEF00D, 1'b1}) begin errors++; $display("[TB] FAIL mt_with_start: got hi=%h lo=%h busy=%b expected cafef00d cafef00d 1", hi, lo, busy); end
        for (int i = 2; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        {exp_hi, exp_lo} = {32'd0, 32'd30};
        checks++; if ({hi, lo} !== {exp_hi, exp_lo} || lat !== MUL_LAT) begin errors++; $display("[TB] FAIL mt_overwritten: got %h lat=%0d expected %h lat=%0d", {hi, lo}, lat, {exp_hi, exp_lo}, MUL_LAT); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ohi, olo; logic od; int lat, nb;
        logic seen;
        seen = 1'b0;
        func = OP_DIVU; a = 32'hFFFF0000; b = 32'd3; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        checks++; if ({hi, lo, busy} !== {32'd0, 32'd0, 1'b0}) begin errors++; $display("[TB] FAIL reset_mid: got hi=%h lo=%h busy=%b expected 0 0 0", hi, lo, busy); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_no_done: got activity=%b expected 0", seen); end
        do_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, ohi, olo, od, lat, nb);
        {exp_hi, exp_lo} = 64'd1;
        checks++; if ({ohi, olo} !== {exp_hi, exp_lo} || lat !== MUL_LAT) begin errors++; $display("[TB] FAIL reset_mid_recover: got %h lat=%0d expected %h lat=%0d", {ohi, olo}, lat, {exp_hi, exp_lo}, MUL_LAT); end
    endtask

    // Test sequence.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div0();
        test_random();
        test_back_to_back();
        test_ignore();
        test_invalid_func();
        test_mt_same_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
